// File: rtl/ysyx_25020047_pkg.sv
// ysyx_25020047_pkg: LSU opcodes, FSM state encoding and byte-mask width
package ysyx_25020047_pkg;
  localparam logic [2:0] LSU_LW  = 3'd0;
  localparam logic [2:0] LSU_LB  = 3'd1;
  localparam logic [2:0] LSU_LBU = 3'd2;
  localparam logic [2:0] LSU_SW  = 3'd3;
  localparam logic [2:0] LSU_SB  = 3'd4;
  localparam int MASK_W = 4;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} lsu_state_e;
endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// ysyx_25020047_lsu_align: store lane placement, load byte extract/extend, error detect
module ysyx_25020047_lsu_align
  import ysyx_25020047_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [1:0]        off,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rdata,
  output logic              err,
  output logic [31:0]       st_wdata,
  output logic [MASK_W-1:0] st_wmask,
  output logic [31:0]       ld_data
);
  logic [7:0] ld_byte;
  // Pure lane steering; loads get an all-zero mask so the top can tell reads from writes
  always_comb begin
    err      = op > LSU_SB || ((op == LSU_LW || op == LSU_SW) && off != 2'b00);
    st_wmask = op == LSU_SW ? {MASK_W{1'b1}} : op == LSU_SB ? MASK_W'(1) << off : '0;
    st_wdata = op == LSU_SW ? wdata : op == LSU_SB ? {4{wdata[7:0]}} : 32'h0;
    ld_byte  = rdata[{off, 3'b000} +: 8];
    ld_data  = op == LSU_LW ? rdata : op == LSU_LB ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
  end
endmodule

// File: rtl/ysyx_25020047_lsu.sv
// ysyx_25020047_lsu: EXU load/store responder; YSYX_25020047_LSU_TIMEOUT_EN adds a WAIT watchdog
module ysyx_25020047_lsu
  import ysyx_25020047_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  lsu_state_e state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;
  logic err_q, err_d;
  logic idle, a_err;
  logic [31:0] a_st_wdata, a_ld;
  logic [MASK_W-1:0] a_st_wmask;
`ifdef YSYX_25020047_LSU_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif
  assign idle      = state_q == S_IDLE;
  assign req_ready = idle;
  assign mem_valid = state_q == S_REQ;
  assign mem_wen   = mem_valid & |wmask_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_wmask = mem_valid ? wmask_q : '0;
  assign rsp_valid = state_q == S_RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  ysyx_25020047_lsu_align u_align (
    .op       (idle ? req_op : op_q),
    .off      (idle ? req_addr[1:0] : addr_q[1:0]),
    .wdata    (req_wdata),
    .rdata    (mem_rdata),
    .err      (a_err),
    .st_wdata (a_st_wdata),
    .st_wmask (a_st_wmask),
    .ld_data  (a_ld)
  );
  // Next state and captured transaction fields; store lanes are registered at acceptance
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef YSYX_25020047_LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: if (req_valid) begin
        op_d    = req_op;
        addr_d  = req_addr;
        wdata_d = a_st_wdata;
        wmask_d = a_st_wmask;
        rdata_d = '0;
        err_d   = a_err;
        state_d = a_err ? S_RESP : S_REQ;
      end
      S_REQ: if (mem_ready) begin
        state_d = |wmask_q ? S_RESP : S_WAIT;
`ifdef YSYX_25020047_LSU_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: if (mem_rvalid) begin
        rdata_d = a_ld;
        state_d = S_RESP;
      end
`ifdef YSYX_25020047_LSU_TIMEOUT_EN
      else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
`endif
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // State and capture registers; async reset aborts any transaction back to IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
`ifdef YSYX_25020047_LSU_TIMEOUT_EN
  // WAIT-cycle watchdog counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif
endmodule
